// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   ARB_DATA_WIDTH / ARB_NUM_REQ : default word width and requester count
//   ARB_CNT_W                    : width of the optional per-requester grant counters
//   arb_state_e                  : output-register state (StEmpty / StHold)
//   rr_next()                    : round-robin successor with explicit wrap
package fifo_wr_arbiter_pkg;

  localparam int unsigned ARB_DATA_WIDTH = 8;
  localparam int unsigned ARB_NUM_REQ    = 4;
  localparam int unsigned ARB_CNT_W      = 16;

  typedef enum logic {
    StEmpty = 1'b0,
    StHold  = 1'b1
  } arb_state_e;

  // Explicit compare instead of truncation so non-power-of-2 counts wrap correctly.
  function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-port bundle for fifo_wr_arbiter.
//   req, req_data  : per-requester request and packed data (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   gnt            : one-hot grant, word consumed this cycle
//   fifo_wr_en     : output register holds a valid word
//   fifo_wr_data   : held word
//   fifo_wr_ready  : FIFO not full
//   last_id        : requester index of the held word
// master = arbiter side, slave = requesters/FIFO side.
interface fifo_wr_arbiter_if
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int unsigned NUM_REQ    = ARB_NUM_REQ
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_wr_ready;
  logic [IDX_W-1:0]              last_id;

  modport master (
    input  req, req_data, fifo_wr_ready,
    output gnt, fifo_wr_en, fifo_wr_data, last_id
  );

  modport slave (
    output req, req_data, fifo_wr_ready,
    input  gnt, fifo_wr_en, fifo_wr_data, last_id
  );

endinterface

// File: rtl/fifo_wr_arbiter_picker.sv
// rr_priority_picker: combinational round-robin priority encoder.
//   req_i     : request vector
//   ptr_i     : highest-priority index this cycle
//   en_i      : grant allowed
//   gnt_o     : one-hot grant, first requester at or above ptr_i (wrapping)
//   gnt_idx_o : index of the granted requester (0 when none)
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  int unsigned      idx;
  logic [IDX_W-1:0] idx_w;
  logic             found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(ptr_i) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_w = IDX_W'(idx);
      if (en_i && !found && req_i[idx_w]) begin
        found        = 1'b1;
        gnt_o[idx_w] = 1'b1;
        gnt_idx_o    = idx_w;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one fifo_shift write port among NUM_REQ
// requesters. A granted word is registered and held on fifo_wr_en/fifo_wr_data until the
// FIFO takes it; a new grant may load the register on the same edge the old word drains.
//   clk, reset : clock (rising edge), synchronous active-high reset
//   bus        : fifo_wr_arbiter_if.master (requests, grants, FIFO write port, last_id)
//   grant_cnt  : per-requester 16-bit saturating grant counters, present only when
//                FIFO_ARB_CNT_EN is defined
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int unsigned NUM_REQ    = ARB_NUM_REQ
) (
  input  logic                         clk,
  input  logic                         reset,
`ifdef FIFO_ARB_CNT_EN
  output logic [NUM_REQ*ARB_CNT_W-1:0] grant_cnt,
`endif
  fifo_wr_arbiter_if.master            bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      last_id_q, last_id_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic                  accept;
  logic                  pick_en;
  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;

  // Register is free, or its word leaves on this edge.
  assign accept  = (state_q == StEmpty) || bus.fifo_wr_ready;
  assign pick_en = accept && !reset;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i     (bus.req),
    .ptr_i     (rr_ptr_q),
    .en_i      (pick_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    last_id_d = last_id_q;
    rr_ptr_d  = rr_ptr_q;
    if (|gnt) begin
      data_d    = bus.req_data[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      last_id_d = gnt_idx;
      state_d   = StHold;
      rr_ptr_d  = IDX_W'(rr_next(32'(gnt_idx), NUM_REQ));
    end else if (state_q == StHold && bus.fifo_wr_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StEmpty;
      data_q    <= '0;
      last_id_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      last_id_q <= last_id_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign bus.gnt          = gnt;
  assign bus.fifo_wr_en   = (state_q == StHold);
  assign bus.fifo_wr_data = data_q;
  assign bus.last_id      = last_id_q;

`ifdef FIFO_ARB_CNT_EN
  logic [NUM_REQ-1:0][ARB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + ARB_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter in front of a 4-deep FIFO occupancy model.
// Expected FIFO write words are queued as stimulus is driven and popped as writes occur.
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned NR    = 4;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic rd_en;
  int   checks = 0;
  int   errors = 0;
  int   fifo_cnt = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

`ifdef FIFO_ARB_CNT_EN
  logic [NR*ARB_CNT_W-1:0] grant_cnt;
`endif

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef FIFO_ARB_CNT_EN
    .grant_cnt (grant_cnt),
`endif
    .bus       (bus)
  );

  // FIFO occupancy model sharing the arbiter reset.
  assign bus.fifo_wr_ready = (fifo_cnt < DEPTH);

  always @(posedge clk) begin
    if (reset) fifo_cnt <= 0;
    else fifo_cnt <= fifo_cnt + ((bus.fifo_wr_en && bus.fifo_wr_ready) ? 1 : 0)
                              - ((rd_en && fifo_cnt > 0) ? 1 : 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: a handshake visible mid-cycle completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset && bus.fifo_wr_en && bus.fifo_wr_ready) begin
      if (sb_q.size() == 0) chk("unexpected_write", 32'(bus.fifo_wr_data), 32'hFFFF_FFFF);
      else chk("write_word", 32'(bus.fifo_wr_data), 32'(sb_q.pop_front()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    bus.req_data[i*DW +: DW] = v;
  endtask

  initial begin
    reset = 1'b1;
    rd_en = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < NR; i++) set_data(i, 8'(i));

    // 1: reset held two cycles with all requests high
    for (int i = 0; i < 2; i++) begin
      cyc();
      #1;
      chk("rst_gnt", 32'(bus.gnt), 32'h0);
      chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'h0);
      chk("rst_wr_data", 32'(bus.fifo_wr_data), 32'h0);
      chk("rst_last_id", 32'(bus.last_id), 32'h0);
    end

    // 2: single requester 2, one-cycle latency to the write port
    reset = 1'b0;
    bus.req = 4'b0100;
    set_data(2, 8'h2A);
    #1;
    chk("single_gnt", 32'(bus.gnt), 32'h4);
    sb_q.push_back(8'h2A);
    cyc();
    bus.req = 4'b0000;
    #1;
    chk("single_wr_en", 32'(bus.fifo_wr_en), 32'h1);
    chk("single_wr_data", 32'(bus.fifo_wr_data), 32'h2A);
    chk("single_last_id", 32'(bus.last_id), 32'h2);
    cyc();

    // 3: all requesting from reset, FIFO not read -> order 0,1,2,3 then full
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rd_en = 1'b0;
    bus.req = 4'b1111;
    for (int i = 0; i < NR; i++) set_data(i, 8'(i));
    sb_q.push_back(8'h00);
    sb_q.push_back(8'h01);
    sb_q.push_back(8'h02);
    sb_q.push_back(8'h03);
    sb_q.push_back(8'h10);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_gnt", 32'(bus.gnt), 32'(1) << (i % 4));
      cyc();
      if (i == 0) set_data(0, 8'h10);
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("full_ready", 32'(bus.fifo_wr_ready), 32'h0);
      chk("full_gnt", 32'(bus.gnt), 32'h0);
      chk("full_wr_en", 32'(bus.fifo_wr_en), 32'h1);
      chk("full_wr_data", 32'(bus.fifo_wr_data), 32'h10);
      chk("full_last_id", 32'(bus.last_id), 32'h0);
      if (i == 0) cyc();
    end

    // 4: one read frees a slot; held word drains and requester 1 granted same cycle
    rd_en = 1'b1;
    #1;
    chk("pulse_ready_before", 32'(bus.fifo_wr_ready), 32'h0);
    cyc();
    rd_en = 1'b0;
    #1;
    chk("drain_ready", 32'(bus.fifo_wr_ready), 32'h1);
    chk("drain_wr_data", 32'(bus.fifo_wr_data), 32'h10);
    chk("drain_gnt", 32'(bus.gnt), 32'h2);
    sb_q.push_back(8'h01);
    cyc();
    #1;
    chk("b2b_wr_en", 32'(bus.fifo_wr_en), 32'h1);
    chk("b2b_wr_data", 32'(bus.fifo_wr_data), 32'h01);
    chk("b2b_last_id", 32'(bus.last_id), 32'h1);
    chk("b2b_gnt", 32'(bus.gnt), 32'h0);

    // 5: move pointer to 3, then requesters 3 and 0 alternate across the wrap
    bus.req = 4'b0000;
    rd_en = 1'b1;
    repeat (6) cyc();
    bus.req = 4'b0100;
    set_data(2, 8'h22);
    #1;
    chk("ptr_set_gnt", 32'(bus.gnt), 32'h4);
    sb_q.push_back(8'h22);
    cyc();
    bus.req = 4'b1001;
    set_data(3, 8'h33);
    set_data(0, 8'h44);
    #1;
    chk("wrap_gnt3", 32'(bus.gnt), 32'h8);
    sb_q.push_back(8'h33);
    cyc();
    #1;
    chk("wrap_gnt0", 32'(bus.gnt), 32'h1);
    chk("wrap_last_id3", 32'(bus.last_id), 32'h3);
    sb_q.push_back(8'h44);
    cyc();
    #1;
    chk("wrap_gnt3_again", 32'(bus.gnt), 32'h8);
    chk("wrap_last_id0", 32'(bus.last_id), 32'h0);
    sb_q.push_back(8'h33);
    cyc();
    bus.req = 4'b0000;

    // 6: fill FIFO from requester 1, then reset while a word is held
    repeat (4) cyc();
    rd_en = 1'b0;
    bus.req = 4'b0010;
    set_data(1, 8'h55);
    for (int i = 0; i < 4; i++) sb_q.push_back(8'h55);
    repeat (5) cyc();
    #1;
    chk("hold_wr_en", 32'(bus.fifo_wr_en), 32'h1);
    chk("hold_ready", 32'(bus.fifo_wr_ready), 32'h0);
    chk("hold_gnt", 32'(bus.gnt), 32'h0);
    chk("hold_last_id", 32'(bus.last_id), 32'h1);
    reset = 1'b1;
    bus.req = 4'b1111;
    #1;
    chk("reset_gnt", 32'(bus.gnt), 32'h0);
    cyc();
    chk("post_rst_wr_en", 32'(bus.fifo_wr_en), 32'h0);
    chk("post_rst_wr_data", 32'(bus.fifo_wr_data), 32'h0);
    chk("post_rst_last_id", 32'(bus.last_id), 32'h0);
`ifdef FIFO_ARB_CNT_EN
    chk("post_rst_cnt_lo", grant_cnt[31:0], 32'h0);
    chk("post_rst_cnt_hi", grant_cnt[63:32], 32'h0);
`endif
    reset = 1'b0;
    for (int i = 0; i < NR; i++) set_data(i, 8'h60 + 8'(i));
    #1;
    chk("post_rst_ptr_gnt", 32'(bus.gnt), 32'h1);
    sb_q.push_back(8'h60);
    cyc();
    bus.req = 4'b0000;
    rd_en = 1'b1;

`ifdef FIFO_ARB_CNT_EN
    // Counter 0 driven past 16'hFFFF must saturate.
    bus.req = 4'b0001;
    set_data(0, 8'h77);
    for (int i = 0; i < 65540; i++) begin
      sb_q.push_back(8'h77);
      cyc();
    end
    bus.req = 4'b0000;
    #1;
    chk("cnt0_saturate", 32'(grant_cnt[15:0]), 32'hFFFF);
    chk("cnt1_idle", 32'(grant_cnt[31:16]), 32'h0);
`endif

    repeat (4) cyc();
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
